// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver timed by a down-counter on the system clock.
// Half-integer bit periods are produced by alternating DIV and DIV+1 reloads.
module uart_rx_os #(
    parameter int BAUD_DIV  = 8,
    parameter int BAUD_HALF = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    localparam logic [CNT_WIDTH-1:0] HALF_LOAD = CNT_WIDTH'((BAUD_DIV >> 1) - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LO    = CNT_WIDTH'(BAUD_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_HI    = CNT_WIDTH'(BAUD_DIV);

    state_t               state, state_n;
    logic                 rx_m, rx_s, rx_p;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           idx;
    logic                 phase, phase_n;
    logic [7:0]           shreg;
    logic                 tick, fall;
    logic                 start_ok, bit_tick, done_ok, done_err;

    assign tick    = cnt == '0;
    assign fall    = rx_p & ~rx_s;
    assign phase_n = (BAUD_HALF != 0) && !phase;

    always_ff @(posedge clock or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = fall ? START : IDLE;
            START:     state_n = tick ? (rx_s ? IDLE : DATA) : START;
            DATA:      state_n = (tick && idx == 3'd7) ? STOP : DATA;
            STOP:      state_n = tick ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        start_ok = state == START && tick && !rx_s;
        bit_tick = state == DATA && tick;
        done_ok  = state == STOP && tick && rx_s;
        done_err = state == STOP && tick && !rx_s;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            {rx_m, rx_s, rx_p} <= 3'b111;
            cnt        <= '0;
            idx        <= '0;
            phase      <= 1'b0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            rx_p       <= rx_s;
            data_valid <= done_ok;
            frame_err  <= done_err;
            if (state == IDLE && fall) cnt <= HALF_LOAD;
            else if (start_ok)         cnt <= DIV_LO;
            else if (bit_tick)         cnt <= phase_n ? DIV_HI : DIV_LO;
            else if (!tick)            cnt <= cnt - 1'b1;
            if (start_ok) begin
                idx   <= '0;
                phase <= 1'b0;
            end
            if (bit_tick) begin
                shreg <= {rx_s, shreg[7:1]};
                idx   <= idx + 3'd1;
                phase <= phase_n;
            end
            if (done_ok || done_err) data_out <= shreg;
        end
    end
endmodule
